// File: rtl/frost32_mem_ctrl.sv
// frost32_mem_ctrl: single-outstanding memory access controller between the Frost32 core and a word bus
// Ports: clk, rst_n (async active-low)
//   core side: cpu_req, cpu_addr, cpu_wdata, cpu_access_type, cpu_access_size -> cpu_rdata, cpu_busy, cpu_done, cpu_err
//   bus side:  mem_req, mem_we, mem_addr (word), mem_be, mem_wdata -> mem_ack, mem_rdata
module frost32_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_access_type,
    input  logic [1:0]  cpu_access_size,
    output logic [31:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  off, off_n, size, size_n;
    logic [31:0] rdata_n, wdata_n, rd_sel, lane_wdata;
    logic [29:0] addr_n;
    logic [3:0]  be_n, lane_be;
    logic        req_n, we_n, err_n, bad;
    assign bad = cpu_access_size == 2'd3 || (cpu_access_size == 2'd1 && cpu_addr[0]) ||
                 (cpu_access_size == 2'd0 && cpu_addr[1:0] != 2'd0);
    assign lane_be = cpu_access_size == 2'd0 ? 4'hf :
                     cpu_access_size == 2'd1 ? (cpu_addr[1] ? 4'b1100 : 4'b0011) :
                     4'b0001 << cpu_addr[1:0];
    assign lane_wdata = cpu_access_size == 2'd0 ? cpu_wdata :
                        cpu_access_size == 2'd1 ? {2{cpu_wdata[15:0]}} : {4{cpu_wdata[7:0]}};
    // extraction uses the latched offset/size, not the live core inputs
    assign rd_sel = size == 2'd0 ? mem_rdata :
                    size == 2'd1 ? {16'h0, off[1] ? mem_rdata[31:16] : mem_rdata[15:0]} :
                    {24'h0, mem_rdata[{off, 3'b000} +: 8]};
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        off_n   = off;
        size_n  = size;
        req_n   = mem_req;
        we_n    = mem_we;
        addr_n  = mem_addr;
        be_n    = mem_be;
        wdata_n = mem_wdata;
        rdata_n = '0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (cpu_req) begin
                off_n   = cpu_addr[1:0];
                size_n  = cpu_access_size;
                we_n    = cpu_access_type;
                addr_n  = cpu_addr[31:2];
                be_n    = lane_be;
                wdata_n = lane_wdata;
                cnt_n   = '0;
                state_n = bad ? DONE : ACCESS;
                req_n   = !bad;
                err_n   = bad;
            end
            ACCESS: begin
                cnt_n = cnt + 16'd1;
                // ack is checked first so a coincident ack beats the timeout
                if (mem_ack) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    rdata_n = mem_we ? '0 : rd_sel;
                end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            off       <= '0;
            size      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_busy  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            off       <= off_n;
            size      <= size_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_be    <= be_n;
            mem_wdata <= wdata_n;
            cpu_rdata <= rdata_n;
            cpu_err   <= err_n;
            cpu_done  <= state_n == DONE;
            cpu_busy  <= state_n != IDLE;
        end
    end
endmodule
